serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder built around one full-adder bit slice and a registered carry.
- Accepts two WIDTH-bit operands and a carry-in on a start pulse.
- Feeds the bit slice one operand bit pair per clock, LSB first, feeding the registered carry back each cycle.
- Returns the WIDTH-bit sum and carry-out with a one-cycle done pulse; serves as the multi-bit adder stage downstream consumers use instead of a ripple chain.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 1..32)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; sum/cout valid from this cycle
sum  output  WIDTH  registered result; held until next accepted start completes
cout  output  1  registered carry-out; held like sum

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0; internal operand shift registers, carry register and bit counter cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch a and b into shift registers, carry_reg<=cin, counter<=0, go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - s_bit = a_sh[0] ^ b_sh[0] ^ carry_reg.
  - carry_reg <= majority(a_sh[0], b_sh[0], carry_reg).
  - Result shift register shifts right with s_bit entering at MSB.
  - a_sh and b_sh shift right (zero fill).
  - counter increments.
  - On the edge that processes bit WIDTH-1: go to DONE, load sum from the final shifted result, cout<=final carry.
- DONE: done=1 for exactly this one cycle, then unconditionally go to IDLE. start is ignored in DONE.
- Latency: start sampled at edge E0; bit i processed at edge E(i+1); done high in the cycle after edge E(WIDTH).
  - Start-to-done is WIDTH+1 cycles.
  - Minimum spacing between accepted starts is WIDTH+2 cycles.
- busy=1 exactly WIDTH cycles, in RUN only.
- start while busy or in DONE: ignored; operands and cin not resampled.
- sum/cout update only on the RUN→DONE edge. They keep the previous result through IDLE and RUN until the new result lands.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- WIDTH=1: single RUN cycle; behaves as one full-adder evaluation with registered outputs.
- Reset during RUN or DONE aborts the operation: no done pulse, sum/cout forced to 0, next start begins cleanly.
- Operand inputs may change freely after the accepting edge without affecting the result.

Test Plan:
- WIDTH=8, reset, then start with a=0x00, b=0x00, cin=0 -> busy high 8 cycles, done pulses once at cycle 9 after start, sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (full carry ripple through all bits).
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; then a=0x5A, b=0x25, cin=1 -> sum=0x80, cout=0. Check sum holds 0xFF during the second RUN until its done cycle.
- Start with a=0x0F, b=0x01, cin=0; pulse start again with a=0xAA, b=0xAA at cycle 3 -> second start ignored, result sum=0x10, cout=0, only one done pulse. Start during the DONE cycle also ignored.
- Start a=0x80, b=0x80, then assert rst_n=0 at cycle 4 for one cycle -> no done pulse, busy=0, sum=0, cout=0 immediately (asynchronous). Fresh start a=0x01, b=0x02, cin=1 -> sum=0x04, cout=0.
- WIDTH=1 build, all eight (a,b,cin) combinations -> {cout,sum} equals the full-adder truth table; done 2 cycles after each start.

Source files
------------

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder. A single full-adder slice is fed one operand bit
// pair per clock, LSB first, with its carry held in a register between cycles.
// A start pulse in IDLE captures both operands and the carry-in. WIDTH cycles
// later the sum and carry-out are loaded into output registers and done
// pulses for one cycle. The outputs hold until the next operation completes.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only in IDLE
//   a      in   WIDTH  operand A, captured on accepted start
//   b      in   WIDTH  operand B, captured on accepted start
//   cin    in   1      carry-in, captured on accepted start
//   busy   out  1      high while bits are being processed (RUN)
//   done   out  1      one-cycle pulse, sum/cout valid from this cycle
//   sum    out  WIDTH  registered sum, held until the next result lands
//   cout   out  1      registered carry-out, held like sum
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A 1-bit counter is kept for WIDTH=1 so the vector never has zero width.
    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   res_d;
    logic [WIDTH-1:0]   sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               carry_d;
    logic               s_bit;
    logic               cout_q;
    logic               busy_q;
    logic               done_q;

    // Full-adder bit slice working on the current LSBs and the stored carry.
    // NOTE: every always_comb output gets a value on every path; a missing
    // assignment would infer a latch.
    always_comb begin
        s_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        carry_d = (a_sh_q[0] & b_sh_q[0]) |
                  (a_sh_q[0] & carry_q)   |
                  (b_sh_q[0] & carry_q);
    end

    // Result shift register: the new sum bit enters at the MSB, so after
    // WIDTH shifts bit 0 of the operands has reached bit 0 of the result.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_d = s_bit;
        end else begin : g_res_wn
            assign res_d = {s_bit, res_q[WIDTH-1:1]};
        end
    endgenerate

    // The result LSB is shifted out on the final edge and never read back.
    logic unused_res_lsb;
    assign unused_res_lsb = res_q[0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand and result shift registers are reset too, so
            // an aborted operation leaves no stale data behind.
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    carry_q <= carry_d;
                    res_q   <= res_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= res_d;
                        cout_q  <= carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Directed bench for serial_adder. An 8-bit instance runs a table of operand
// vectors with hand-computed results, followed by hand-written sequences for
// ignored starts and a mid-operation reset. A 1-bit instance runs the
// full-adder truth table.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int n_cmp;
    int n_err;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec8_t;

    typedef struct {
        logic [0:0] a;
        logic [0:0] b;
        logic       cin;
        logic [0:0] exp_sum;
        logic       exp_cout;
    } vec1_t;

    vec8_t vecs8[7];
    vec1_t vecs1[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit operation. hold_* is the result expected on sum/cout until the
    // new result lands. restart_at (>0) re-pulses start with other operands in
    // that RUN cycle; start_in_done raises start during the DONE cycle.
    task automatic run8(input string tag,
                        input logic [7:0] a_v, input logic [7:0] b_v, input logic cin_v,
                        input logic [7:0] exp_s, input logic exp_c,
                        input logic [7:0] hold_s, input logic hold_c,
                        input int restart_at, input bit start_in_done);
        int cycles;
        int busy_cnt;
        bit hold_ok;
        a8     = a_v;
        b8     = b_v;
        cin8   = cin_v;
        start8 = 1'b1;
        tick();
        // Operands are scrambled right after the accepting edge.
        start8   = 1'b0;
        a8       = ~a_v;
        b8       = ~b_v;
        cin8     = ~cin_v;
        cycles   = 1;
        busy_cnt = 0;
        hold_ok  = 1'b1;
        while (!done8 && cycles < 40) begin
            if (busy8) busy_cnt++;
            if (sum8 !== hold_s || cout8 !== hold_c) hold_ok = 1'b0;
            if (cycles == restart_at) begin
                start8 = 1'b1;
                a8     = 8'hAA;
                b8     = 8'hAA;
            end else begin
                start8 = 1'b0;
            end
            tick();
            cycles++;
        end
        check({tag, " done"}, 64'(done8), 64'd1);
        check({tag, " latency"}, 64'(cycles), 64'd9);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd8);
        check({tag, " hold_prev"}, 64'(hold_ok), 64'd1);
        check({tag, " sum"}, 64'(sum8), 64'(exp_s));
        check({tag, " cout"}, 64'(cout8), 64'(exp_c));
        check({tag, " busy_in_done"}, 64'(busy8), 64'd0);
        if (start_in_done) begin
            start8 = 1'b1;
            a8     = 8'h11;
            b8     = 8'h22;
        end
        tick();
        start8 = 1'b0;
        check({tag, " done_single"}, 64'(done8), 64'd0);
        check({tag, " idle_after"}, 64'(busy8), 64'd0);
        check({tag, " sum_held"}, 64'(sum8), 64'(exp_s));
    endtask

    task automatic run1(input string tag, input vec1_t v);
        int cycles;
        a1     = v.a;
        b1     = v.b;
        cin1   = v.cin;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cycles = 1;
        while (!done1 && cycles < 10) begin
            tick();
            cycles++;
        end
        check({tag, " done"}, 64'(done1), 64'd1);
        check({tag, " latency"}, 64'(cycles), 64'd2);
        check({tag, " sum"}, 64'(sum1), 64'(v.exp_sum));
        check({tag, " cout"}, 64'(cout1), 64'(v.exp_cout));
        tick();
        check({tag, " done_single"}, 64'(done1), 64'd0);
    endtask

    initial begin
        int dones;
        logic [7:0] prev_s;
        logic       prev_c;

        n_cmp = 0;
        n_err = 0;

        vecs8[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs8[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs8[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs8[3] = '{8'h5A, 8'h25, 1'b1, 8'h80, 1'b0};
        vecs8[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs8[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs8[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        vecs1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rst_n  = 1'b0;
        start8 = 1'b0;
        a8     = 8'h00;
        b8     = 8'h00;
        cin8   = 1'b0;
        start1 = 1'b0;
        a1     = 1'b0;
        b1     = 1'b0;
        cin1   = 1'b0;

        repeat (2) tick();
        check("reset busy8", 64'(busy8), 64'd0);
        check("reset done8", 64'(done8), 64'd0);
        check("reset sum8", 64'(sum8), 64'd0);
        check("reset cout8", 64'(cout8), 64'd0);
        check("reset busy1", 64'(busy1), 64'd0);
        check("reset sum1", 64'(sum1), 64'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven 8-bit vectors; each run also checks that the previous
        // result is held through the new RUN phase.
        prev_s = 8'h00;
        prev_c = 1'b0;
        for (int i = 0; i < 7; i++) begin
            run8($sformatf("vec8[%0d]", i), vecs8[i].a, vecs8[i].b, vecs8[i].cin,
                 vecs8[i].exp_sum, vecs8[i].exp_cout, prev_s, prev_c, 0, 1'b0);
            prev_s = vecs8[i].exp_sum;
            prev_c = vecs8[i].exp_cout;
        end

        // Start re-pulsed mid-RUN and again during DONE: both ignored.
        run8("ignore_start", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, prev_s, prev_c, 3, 1'b1);

        // Reset in the middle of an operation.
        a8     = 8'h80;
        b8     = 8'h80;
        cin8   = 1'b0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        check("abort busy_before", 64'(busy8), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy8), 64'd0);
        check("abort sum", 64'(sum8), 64'd0);
        check("abort cout", 64'(cout8), 64'd0);
        check("abort done", 64'(done8), 64'd0);
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) dones++;
            tick();
        end
        check("abort no_activity", 64'(dones), 64'd0);
        run8("after_abort", 8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 0, 1'b0);

        // WIDTH=1 truth table.
        for (int i = 0; i < 8; i++) begin
            run1($sformatf("vec1[%0d]", i), vecs1[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
